// File: rtl/mem_wb_stage_pkg.sv
// Shared RV32I writeback constants and the MEM/WB entry layout.
package mem_wb_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INSTRET_W  = 64;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [1:0]            wb_sel;
        logic [2:0]            funct3;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       mem_rdata;
        logic [XLEN-1:0]       pc_plus4;
    } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bundle plus the writeback/forwarding outputs.
// RETIRE_CNT_EN adds the instret counter output.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic [1:0]            in_wb_sel;
    logic [2:0]            in_funct3;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_mem_rdata;
    logic [XLEN-1:0]       in_pc_plus4;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic [XLEN-1:0]       wb_data;
    logic                  load_err;
`ifdef RETIRE_CNT_EN
    logic [INSTRET_W-1:0]  instret;
`endif

    modport master (
        output stall, flush, in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4,
        input  wb_valid, wb_rd, wb_reg_write, wb_data, load_err
`ifdef RETIRE_CNT_EN
        , input instret
`endif
    );

    modport slave (
        input  stall, flush, in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4,
        output wb_valid, wb_rd, wb_reg_write, wb_data, load_err
`ifdef RETIRE_CNT_EN
        , output instret
`endif
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Extracts and extends load data from the raw memory word; flags bad alignment/funct3.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{off, 3'b000} +: 8];
    assign sel_half = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH: begin
                data = {{16{sel_half[15]}}, sel_half};
                err  = off[0];
            end
            F3_LW: begin
                data = rdata;
                err  = (off != 2'b00);
            end
            F3_LBU:  data = {24'b0, sel_byte};
            F3_LHU: begin
                data = {16'b0, sel_half};
                err  = off[0];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: source mux, load extraction, write gating.
// Define RETIRE_CNT_EN to add the retired-instruction counter (instret).
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    mem_wb_entry_t   entry_q;
    logic [XLEN-1:0] load_data;
    logic            align_err;
    logic            is_load;
    logic            load_err;

    // Flush only drops valid; the stale payload is harmless once valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else if (bus.flush) begin
            entry_q.valid <= 1'b0;
        end else if (!bus.stall) begin
            entry_q <= '{valid:      bus.in_valid,
                         rd:         bus.in_rd,
                         reg_write:  bus.in_reg_write,
                         wb_sel:     bus.in_wb_sel,
                         funct3:     bus.in_funct3,
                         alu_result: bus.in_alu_result,
                         mem_rdata:  bus.in_mem_rdata,
                         pc_plus4:   bus.in_pc_plus4};
        end
    end

    mem_wb_stage_load_align u_load_align (
        .rdata  (entry_q.mem_rdata),
        .off    (entry_q.alu_result[1:0]),
        .funct3 (entry_q.funct3),
        .data   (load_data),
        .err    (align_err)
    );

    assign is_load  = (entry_q.wb_sel == WB_SEL_LOAD);
    assign load_err = entry_q.valid & is_load & align_err;

    always_comb begin
        bus.wb_data = entry_q.alu_result;
        case (entry_q.wb_sel)
            WB_SEL_LOAD: bus.wb_data = align_err ? '0 : load_data;
            WB_SEL_PC4:  bus.wb_data = entry_q.pc_plus4;
            default:     bus.wb_data = entry_q.alu_result;
        endcase
    end

    assign bus.wb_valid     = entry_q.valid;
    assign bus.wb_rd        = entry_q.rd;
    assign bus.load_err     = load_err;
    assign bus.wb_reg_write = entry_q.valid & entry_q.reg_write & (entry_q.rd != '0) & ~load_err;

`ifdef RETIRE_CNT_EN
    logic [INSTRET_W-1:0] instret_q;

    // An entry retires on the edge it leaves WB, which a stall prevents.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (entry_q.valid && !bus.stall) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign bus.instret = instret_q;
`endif

endmodule
